// File: rtl/mem_access.sv
// MIPS memory-access stage: EX/MEM and MEM/WB pipeline registers around an
// internal little-endian, byte-addressed data memory with byte/half/word access.
module mem_access #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [BITS_SIZE-1:0] i_alu_result,
  input  logic [BITS_SIZE-1:0] i_store_data,
  input  logic [BITS_REGS-1:0] i_rd,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_mem_size,
  input  logic                 i_mem_unsigned,
  input  logic                 i_reg_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic [BITS_SIZE-1:0] o_exmem_register,
  output logic [BITS_REGS-1:0] o_exmem_rd,
  output logic                 o_exmem_reg_write,
  output logic [BITS_SIZE-1:0] o_wb_read_data,
  output logic [BITS_SIZE-1:0] o_wb_alu_result,
  output logic [BITS_REGS-1:0] o_wb_rd,
  output logic                 o_wb_reg_write,
  output logic                 o_wb_mem_to_reg,
  output logic                 o_wb_valid,
  output logic                 o_wb_misaligned
);

  localparam int ADDR_BITS = $clog2(MEM_DEPTH);

  logic [BITS_SIZE-1:0] exmem_alu;
  logic [BITS_SIZE-1:0] exmem_store;
  logic [BITS_REGS-1:0] exmem_rd;
  logic                 exmem_valid;
  logic                 exmem_mem_read;
  logic                 exmem_mem_write;
  logic [1:0]           exmem_size;
  logic                 exmem_unsigned;
  logic                 exmem_reg_write;
  logic                 exmem_mem_to_reg;

  logic [BITS_SIZE-1:0] wb_read_data;
  logic [BITS_SIZE-1:0] wb_alu;
  logic [BITS_REGS-1:0] wb_rd;
  logic                 wb_reg_write;
  logic                 wb_mem_to_reg;
  logic                 wb_valid;
  logic                 wb_misaligned;

  logic [31:0]          mem [MEM_DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic [31:0]          mem_word;
  logic [31:0]          shifted;
  logic [31:0]          load_word;
  logic [BITS_SIZE-1:0] load_data;
  logic                 misaligned;
  logic [3:0]           byte_en;
  logic [31:0]          wdata;
  logic                 mem_we;

  // Flush wins over stall so a squashed instruction never lingers in EX/MEM.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exmem_alu        <= '0;
      exmem_store      <= '0;
      exmem_rd         <= '0;
      exmem_valid      <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_size       <= 2'b00;
      exmem_unsigned   <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else if (i_flush) begin
      exmem_alu        <= '0;
      exmem_store      <= '0;
      exmem_rd         <= '0;
      exmem_valid      <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_size       <= 2'b00;
      exmem_unsigned   <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else if (!i_stall) begin
      exmem_alu        <= i_alu_result;
      exmem_store      <= i_store_data;
      exmem_rd         <= i_rd;
      exmem_valid      <= i_valid;
      exmem_mem_read   <= i_mem_read;
      exmem_mem_write  <= i_mem_write;
      exmem_size       <= i_mem_size;
      exmem_unsigned   <= i_mem_unsigned;
      exmem_reg_write  <= i_reg_write;
      exmem_mem_to_reg <= i_mem_to_reg;
    end
  end

  assign word_idx = exmem_alu[ADDR_BITS+1:2];
  assign lane     = exmem_alu[1:0];
  assign mem_word = mem[word_idx];

  always_comb begin
    misaligned = 1'b0;
    if (exmem_valid && (exmem_mem_read || exmem_mem_write)) begin
      case (exmem_size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = lane[0];
        default: misaligned = |lane;
      endcase
    end
  end

  // Shifting the lane down to bit 0 lets byte and half loads share one extractor.
  always_comb begin
    shifted   = mem_word >> {lane, 3'b000};
    load_word = '0;
    case (exmem_size)
      2'b00:   load_word = {{24{~exmem_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_word = {{16{~exmem_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_word = mem_word;
    endcase
    if (!(exmem_valid && exmem_mem_read) || misaligned) begin
      load_word = '0;
    end
  end

  assign load_data = BITS_SIZE'($signed(load_word));

  always_comb begin
    byte_en = 4'b0000;
    wdata   = exmem_store[31:0];
    case (exmem_size)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wdata   = {4{exmem_store[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{exmem_store[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // Reset clears EX/MEM asynchronously, so a store caught by reset is dropped here too.
  assign mem_we = exmem_valid && exmem_mem_write && !misaligned && !i_stall;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && byte_en[b]) begin
        mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_read_data  <= '0;
      wb_alu        <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (!i_stall) begin
      wb_read_data  <= load_data;
      wb_alu        <= exmem_alu;
      wb_rd         <= exmem_rd;
      wb_reg_write  <= exmem_reg_write && !misaligned;
      wb_mem_to_reg <= exmem_mem_to_reg;
      wb_valid      <= exmem_valid;
      wb_misaligned <= misaligned;
    end
  end

  assign o_exmem_register  = exmem_alu;
  assign o_exmem_rd        = exmem_rd;
  assign o_exmem_reg_write = exmem_reg_write;
  assign o_wb_read_data    = wb_read_data;
  assign o_wb_alu_result   = wb_alu;
  assign o_wb_rd           = wb_rd;
  assign o_wb_reg_write    = wb_reg_write;
  assign o_wb_mem_to_reg   = wb_mem_to_reg;
  assign o_wb_valid        = wb_valid;
  assign o_wb_misaligned   = wb_misaligned;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed load/store scenarios plus random
// traffic compared against a byte-array reference model of the stage.
module tb_mem_access;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic        i_reg_write;
  logic        i_mem_to_reg;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] o_exmem_register;
  logic [4:0]  o_exmem_rd;
  logic        o_exmem_reg_write;
  logic [31:0] o_wb_read_data;
  logic [31:0] o_wb_alu_result;
  logic [4:0]  o_wb_rd;
  logic        o_wb_reg_write;
  logic        o_wb_mem_to_reg;
  logic        o_wb_valid;
  logic        o_wb_misaligned;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        uns;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } instr_t;

  // Reference state: one in-flight instruction, the write-back view, and a byte memory.
  instr_t      ex_m;
  logic [31:0] wb_data_m;
  logic [31:0] wb_alu_m;
  logic [4:0]  wb_rd_m;
  logic        wb_rw_m;
  logic        wb_m2r_m;
  logic        wb_valid_m;
  logic        wb_mis_m;
  logic [7:0]  mem_m [BYTES];

  mem_access #(.BITS_SIZE(32), .BITS_REGS(5), .MEM_DEPTH(DEPTH)) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_alu_result      (i_alu_result),
    .i_store_data      (i_store_data),
    .i_rd              (i_rd),
    .i_valid           (i_valid),
    .i_mem_read        (i_mem_read),
    .i_mem_write       (i_mem_write),
    .i_mem_size        (i_mem_size),
    .i_mem_unsigned    (i_mem_unsigned),
    .i_reg_write       (i_reg_write),
    .i_mem_to_reg      (i_mem_to_reg),
    .i_stall           (i_stall),
    .i_flush           (i_flush),
    .o_exmem_register  (o_exmem_register),
    .o_exmem_rd        (o_exmem_rd),
    .o_exmem_reg_write (o_exmem_reg_write),
    .o_wb_read_data    (o_wb_read_data),
    .o_wb_alu_result   (o_wb_alu_result),
    .o_wb_rd           (o_wb_rd),
    .o_wb_reg_write    (o_wb_reg_write),
    .o_wb_mem_to_reg   (o_wb_mem_to_reg),
    .o_wb_valid        (o_wb_valid),
    .o_wb_misaligned   (o_wb_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b = '{valid: 1'b0, mem_read: 1'b0, mem_write: 1'b0, size: 2'b00, uns: 1'b0,
          reg_write: 1'b0, mem_to_reg: 1'b0, addr: 32'h0, data: 32'h0, rd: 5'h0};
    return b;
  endfunction

  function automatic instr_t mkLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    instr_t s;
    s = bubble();
    s.valid = 1'b1; s.mem_read = 1'b1; s.size = size; s.uns = uns;
    s.reg_write = 1'b1; s.mem_to_reg = 1'b1; s.addr = addr; s.rd = 5'd9;
    return s;
  endfunction

  function automatic instr_t mkStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    instr_t s;
    s = bubble();
    s.valid = 1'b1; s.mem_write = 1'b1; s.size = size; s.addr = addr; s.data = data;
    return s;
  endfunction

  function automatic logic isMisaligned(input instr_t e);
    if (!e.valid || !(e.mem_read || e.mem_write)) return 1'b0;
    if (e.size == 2'd0) return 1'b0;
    if (e.size == 2'd1) return (e.addr % 2) != 0;
    return (e.addr % 4) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input instr_t e);
    int a;
    int v;
    a = int'(e.addr % BYTES);
    if (!e.valid || !e.mem_read || isMisaligned(e)) return 32'h0;
    if (e.size == 2'd0) begin
      v = int'(mem_m[a]);
      if (!e.uns && v >= 128) v -= 256;
      return 32'(v);
    end
    if (e.size == 2'd1) begin
      v = int'(mem_m[a]) + 256 * int'(mem_m[a+1]);
      if (!e.uns && v >= 32768) v -= 65536;
      return 32'(v);
    end
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  task automatic modelStore(input instr_t e);
    int a;
    int n;
    logic [31:0] d;
    if (!e.valid || !e.mem_write || isMisaligned(e)) return;
    a = int'(e.addr % BYTES);
    n = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
    d = e.data;
    for (int k = 0; k < n; k++) begin
      mem_m[a+k] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic modelStep(input instr_t s, input logic stall, input logic flush);
    logic mis;
    if (!i_reset_n) begin
      ex_m = bubble();
      wb_data_m = '0; wb_alu_m = '0; wb_rd_m = '0;
      wb_rw_m = 0; wb_m2r_m = 0; wb_valid_m = 0; wb_mis_m = 0;
      return;
    end
    if (!stall) begin
      mis        = isMisaligned(ex_m);
      wb_data_m  = modelLoad(ex_m);
      modelStore(ex_m);
      wb_alu_m   = ex_m.addr;
      wb_rd_m    = ex_m.rd;
      wb_valid_m = ex_m.valid;
      wb_mis_m   = mis;
      wb_rw_m    = ex_m.reg_write && !mis;
      wb_m2r_m   = ex_m.mem_to_reg;
    end
    if (flush) ex_m = bubble();
    else if (!stall) ex_m = s;
  endtask

  task automatic checkAll();
    checkOutput("exmem_register", o_exmem_register, ex_m.addr);
    checkOutput("exmem_rd", 32'(o_exmem_rd), 32'(ex_m.rd));
    checkOutput("exmem_reg_write", 32'(o_exmem_reg_write), 32'(ex_m.reg_write));
    checkOutput("wb_read_data", o_wb_read_data, wb_data_m);
    checkOutput("wb_alu_result", o_wb_alu_result, wb_alu_m);
    checkOutput("wb_rd", 32'(o_wb_rd), 32'(wb_rd_m));
    checkOutput("wb_reg_write", 32'(o_wb_reg_write), 32'(wb_rw_m));
    checkOutput("wb_mem_to_reg", 32'(o_wb_mem_to_reg), 32'(wb_m2r_m));
    checkOutput("wb_valid", 32'(o_wb_valid), 32'(wb_valid_m));
    checkOutput("wb_misaligned", 32'(o_wb_misaligned), 32'(wb_mis_m));
  endtask

  // Drive on the falling edge, step the model at the rising edge, compare 1 time unit later.
  task automatic applyStimulus(input instr_t s, input logic stall, input logic flush, input logic rst_n);
    @(negedge i_clk);
    i_reset_n      = rst_n;
    i_alu_result   = s.addr;
    i_store_data   = s.data;
    i_rd           = s.rd;
    i_valid        = s.valid;
    i_mem_read     = s.mem_read;
    i_mem_write    = s.mem_write;
    i_mem_size     = s.size;
    i_mem_unsigned = s.uns;
    i_reg_write    = s.reg_write;
    i_mem_to_reg   = s.mem_to_reg;
    i_stall        = stall;
    i_flush        = flush;
    @(posedge i_clk);
    modelStep(s, stall, flush);
    #1;
    checkAll();
  endtask

  task automatic loadCheck(input string tag, input instr_t ld, input logic [31:0] exp);
    applyStimulus(ld, 1'b0, 1'b0, 1'b1);
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b1);
    checkOutput(tag, o_wb_read_data, exp);
  endtask

  function automatic instr_t randInstr();
    instr_t s;
    int op;
    s.valid      = ($urandom_range(0, 3) != 0);
    op           = s.valid ? int'($urandom_range(0, 2)) : 0;
    s.mem_read   = (op == 1);
    s.mem_write  = (op == 2);
    s.size       = 2'($urandom);
    s.uns        = 1'($urandom);
    s.reg_write  = 1'($urandom);
    s.mem_to_reg = 1'($urandom);
    s.addr       = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
    s.data       = $urandom;
    s.rd         = 5'($urandom);
    return s;
  endfunction

  initial begin
    instr_t s;
    ex_m = bubble();
    wb_data_m = '0; wb_alu_m = '0; wb_rd_m = '0;
    wb_rw_m = 0; wb_m2r_m = 0; wb_valid_m = 0; wb_mis_m = 0;
    i_reset_n = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;

    for (int i = 0; i < 4; i++) applyStimulus(randInstr(), 1'($urandom), 1'($urandom), 1'b0);
    checkOutput("reset_wb_valid", 32'(o_wb_valid), 32'h0);

    for (int w = 0; w < DEPTH; w++) applyStimulus(mkStore(32'(w * 4), 2'd2, $urandom), 1'b0, 1'b0, 1'b1);

    applyStimulus(mkStore(32'h10, 2'd2, 32'hDEADBEEF), 1'b0, 1'b0, 1'b1);
    loadCheck("lw_10", mkLoad(32'h10, 2'd2, 1'b0), 32'hDEADBEEF);
    loadCheck("lb_13", mkLoad(32'h13, 2'd0, 1'b0), 32'hFFFFFFDE);
    loadCheck("lbu_13", mkLoad(32'h13, 2'd0, 1'b1), 32'h000000DE);
    loadCheck("lh_10", mkLoad(32'h10, 2'd1, 1'b0), 32'hFFFFBEEF);
    loadCheck("lhu_12", mkLoad(32'h12, 2'd1, 1'b1), 32'h0000DEAD);

    applyStimulus(mkStore(32'h11, 2'd0, 32'h12345678), 1'b0, 1'b0, 1'b1);
    loadCheck("sb_11", mkLoad(32'h10, 2'd2, 1'b0), 32'hDEAD78EF);
    applyStimulus(mkStore(32'h12, 2'd1, 32'hAAAA5555), 1'b0, 1'b0, 1'b1);
    loadCheck("sh_12", mkLoad(32'h10, 2'd2, 1'b0), 32'h555578EF);

    loadCheck("lw_12_data", mkLoad(32'h12, 2'd2, 1'b0), 32'h0);
    checkOutput("lw_12_misaligned", 32'(o_wb_misaligned), 32'h1);
    checkOutput("lw_12_reg_write", 32'(o_wb_reg_write), 32'h0);
    applyStimulus(mkStore(32'h11, 2'd1, 32'h0000FFFF), 1'b0, 1'b0, 1'b1);
    loadCheck("sh_11_unchanged", mkLoad(32'h10, 2'd2, 1'b0), 32'h555578EF);

    applyStimulus(mkStore(32'h20, 2'd2, 32'hCAFEF00D), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(mkLoad(32'h44, 2'd2, 1'b0), 1'b1, 1'b0, 1'b1);
    checkOutput("stall_exmem_held", o_exmem_register, 32'h20);
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b1);
    loadCheck("stall_store", mkLoad(32'h20, 2'd2, 1'b0), 32'hCAFEF00D);

    applyStimulus(mkStore(32'h20, 2'd2, 32'h11111111), 1'b0, 1'b1, 1'b1);
    checkOutput("flush_exmem_register", o_exmem_register, 32'h0);
    loadCheck("flush_no_write", mkLoad(32'h20, 2'd2, 1'b0), 32'hCAFEF00D);

    s = mkStore(32'h400, 2'd2, 32'h0BADF00D);
    applyStimulus(s, 1'b0, 1'b0, 1'b1);
    checkOutput("fwd_register", o_exmem_register, 32'h400);
    loadCheck("wrap_400", mkLoad(32'h000, 2'd2, 1'b0), 32'h0BADF00D);

    applyStimulus(mkStore(32'h30, 2'd2, 32'h77777777), 1'b0, 1'b0, 1'b1);
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b0);
    applyStimulus(mkLoad(32'h30, 2'd2, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 2500; i++) begin
      applyStimulus(randInstr(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Captures the execute stage's ALU result, store data, destination register and control bits in an EX/MEM register, performs byte/halfword/word loads and stores against an internal byte-addressed data memory, and presents the results in a MEM/WB register for write-back. Also exports the EX/MEM value, destination and write-enable so the execute stage's forwarding muxes can use them.

## Interface
- BITS_SIZE, 32, datapath width
- BITS_REGS, 5, register index width
- MEM_DEPTH, 256, data memory depth in 32-bit words; power of two
- i_clk  in  1  clock; all registers update on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_alu_result  in  BITS_SIZE  execute-stage ALU result; byte address for loads/stores
- i_store_data  in  BITS_SIZE  forwarded rt value to store
- i_rd  in  BITS_REGS  destination register selected by execute
- i_valid  in  1  execute-stage instruction is real (not a bubble)
- i_mem_read, i_mem_write  in  1 each  load / store
- i_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- i_reg_write, i_mem_to_reg  in  1 each  write-back controls, carried through
- i_stall  in  1  hold both pipeline registers
- i_flush  in  1  load a bubble into EX/MEM
- o_exmem_register  out  BITS_SIZE  EX/MEM ALU result (forwarding source)
- o_exmem_rd  out  BITS_REGS; o_exmem_reg_write  out  1  (forwarding)
- o_wb_read_data, o_wb_alu_result  out  BITS_SIZE  MEM/WB load data / ALU result
- o_wb_rd  out  BITS_REGS; o_wb_reg_write, o_wb_mem_to_reg, o_wb_valid  out  1 each
- o_wb_misaligned  out  1  instruction in MEM/WB had a misaligned access

## Operation
- EX/MEM register: on each edge with i_stall=0 captures all i_* fields. With i_flush=1 (priority over i_stall) captures a bubble: valid, mem_read, mem_write, reg_write, mem_to_reg all 0; data fields 0.
- Word index = address[log2(MEM_DEPTH)+1:2]; upper address bits ignored (address wraps modulo 4*MEM_DEPTH bytes). Byte lane = address[1:0], little-endian (lane 0 = bits 7:0).
- Alignment: half requires address[0]=0; word requires address[1:0]=00; byte always aligned.
- Store: when EX/MEM holds valid, mem_write, aligned, and i_stall=0, write at the edge: byte writes store_data[7:0] into its lane only; half writes store_data[15:0] into lanes {address[1],0} and {address[1],1}; word writes all lanes. Other lanes untouched. Misaligned store writes nothing.
- Load: combinational read of EX/MEM word; select lane(s); sign-extend unless unsigned; word ignores unsigned. Misaligned load or non-load yields 0.
- MEM/WB register: on each edge with i_stall=0 captures load data, EX/MEM ALU result, rd, valid, reg_write, mem_to_reg and misaligned flag. Misaligned access forces reg_write=0 in MEM/WB.
- Memory contents are not affected by reset.

## Timing
- Reset (asynchronous assert, synchronous-edge release): every output and every pipeline-register field = 0.
- Latency: execute values visible on o_exmem_* one edge later; on o_wb_* two edges later.
- Store committed at the edge that moves it from EX/MEM to MEM/WB; a load in the following instruction (next cycle in EX/MEM) reads the new value (no bypass needed).
- Stall: both registers hold; no memory write occurs while stalled, so a stalled store writes exactly once.
- Flush and stall together: EX/MEM becomes bubble, MEM/WB holds.
- Reset asserted mid-store: the in-flight store is dropped if reset is low at its commit edge.

## Test plan
- Reset: i_reset_n=0 with random inputs -> all outputs 0; release, apply SW of 0xDEADBEEF to 0x10, then LW 0x10 -> o_wb_read_data=0xDEADBEEF two cycles after the LW enters.
- Sub-word loads from 0x10 holding 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- Sub-word stores: SB 0x11 data 0x12345678 then LW 0x10 -> 0xDEAD78EF; SH 0x12 data 0xAAAA5555 -> LW 0x10 = 0x555578EF.
- Misalignment: LW 0x12 -> o_wb_misaligned=1, o_wb_reg_write=0, o_wb_read_data=0; SH 0x11 -> memory unchanged.
- Stall/flush: SW held with i_stall=1 for 3 cycles -> one write, o_wb_* frozen, o_exmem_* stable; i_flush=1 with a store in EX -> next cycle o_exmem_reg_write=0, memory unchanged.
- Wrap and forwarding: SW to 0x400 with MEM_DEPTH=256 -> LW 0x000 returns stored value; o_exmem_register equals previous cycle's i_alu_result.
